oled_spi_rx: RTL and testbench

Display-side SPI receiver for the OLED link: the receiving end of the byte stream the game's SPI transmitter drives on `oled_clk`/`oled_mosi`/`oled_dc`/`oled_cs_n`. It deserialises MSB-first bytes and decodes SSD1306-style addressing commands (0x21, 0x22, 0xAE, 0xAF). It writes data bytes into a 128×8-page framebuffer with a synchronous read port. Used as an in-fabric display model for loopback testing and as a capture front end for a second board.

---
 rtl/oled_spi_rx.sv | 194 +++++++++++++++++++
 tb/tb_oled_spi_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_rx.sv
// SPI receiver for the OLED link: byte deserialiser, SSD1306-style command decode
// and (with OLED_RX_FB_EN defined) a paged framebuffer with a synchronous read port.
module oled_spi_rx #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_clk,
  input  logic                       mosi,
  input  logic                       dc,
  input  logic                       cs_n,
  output logic [7:0]                 byte_data,
  output logic                       byte_dc,
  output logic                       byte_valid,
  output logic                       display_on,
  input  logic [$clog2(PAGES)-1:0]   rd_page,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  output logic [7:0]                 rd_data
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  logic [1:0] sclk_s, mosi_s, dc_s, cs_s;
  logic       sclk_q, rise;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic       done, dc_l;
  logic       on_set, on_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      mosi_s <= '0;
      dc_s   <= '0;
      cs_s   <= 2'b11;
      sclk_q <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], spi_clk};
      mosi_s <= {mosi_s[0], mosi};
      dc_s   <= {dc_s[0], dc};
      cs_s   <= {cs_s[0], cs_n};
      sclk_q <= sclk_s[1];
    end
  end

  assign rise = sclk_s[1] & ~sclk_q;

  // done marks a complete byte in shreg; it is dispatched on the next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      dc_l  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cs_s[1]) begin
        cnt <= '0;
      end else if (rise) begin
        shreg <= {shreg[6:0], mosi_s[1]};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          done <= 1'b1;
          dc_l <= dc_s[1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_data  <= '0;
      byte_dc    <= 1'b0;
      byte_valid <= 1'b0;
      display_on <= 1'b0;
    end else begin
      byte_valid <= done;
      if (done) begin
        byte_data <= shreg;
        byte_dc   <= dc_l;
      end
      if (on_set) display_on <= 1'b1;
      else if (on_clr) display_on <= 1'b0;
    end
  end

`ifdef OLED_RX_FB_EN
  typedef enum logic [2:0] {IDLE, COL_S, COL_E, PG_S, PG_E} state_t;

  state_t          state, state_n;
  logic            ld_cs, ld_ce, ld_ps, ld_pe, wr;
  logic [CW-1:0]   col_start, col_end, col_ptr;
  logic [PW-1:0]   pg_start, pg_end, pg_ptr;
  logic [7:0]      fb [PAGES*COLS];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    ld_cs   = 1'b0;
    ld_ce   = 1'b0;
    ld_ps   = 1'b0;
    ld_pe   = 1'b0;
    wr      = 1'b0;
    on_set  = 1'b0;
    on_clr  = 1'b0;
    if (done) begin
      if (dc_l) begin
        wr      = 1'b1;
        state_n = IDLE;
      end else begin
        case (state)
          IDLE: begin
            case (shreg)
              8'h21:   state_n = COL_S;
              8'h22:   state_n = PG_S;
              8'hAE:   on_clr  = 1'b1;
              8'hAF:   on_set  = 1'b1;
              default: state_n = IDLE;
            endcase
          end
          COL_S: begin
            ld_cs   = 1'b1;
            state_n = COL_E;
          end
          COL_E: begin
            ld_ce   = 1'b1;
            state_n = IDLE;
          end
          PG_S: begin
            ld_ps   = 1'b1;
            state_n = PG_E;
          end
          PG_E: begin
            ld_pe   = 1'b1;
            state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // start > end is legal: pointers simply wrap modulo their width
  always_ff @(posedge clk) begin
    if (rst) begin
      col_start <= '0;
      col_end   <= '1;
      pg_start  <= '0;
      pg_end    <= '1;
      col_ptr   <= '0;
      pg_ptr    <= '0;
    end else begin
      if (ld_cs) col_start <= shreg[CW-1:0];
      if (ld_ce) begin
        col_end <= shreg[CW-1:0];
        col_ptr <= col_start;
      end
      if (ld_ps) pg_start <= shreg[PW-1:0];
      if (ld_pe) begin
        pg_end <= shreg[PW-1:0];
        pg_ptr <= pg_start;
      end
      if (wr) begin
        if (col_ptr == col_end) begin
          col_ptr <= col_start;
          pg_ptr  <= (pg_ptr == pg_end) ? pg_start : pg_ptr + 1'b1;
        end else begin
          col_ptr <= col_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !rst) fb[{pg_ptr, col_ptr}] <= shreg;
    if (rst) rd_data <= '0;
    else rd_data <= fb[{rd_page, rd_col}];
  end
`else
  logic unused_rd;

  assign on_set    = done & ~dc_l & (shreg == 8'hAF);
  assign on_clr    = done & ~dc_l & (shreg == 8'hAE);
  assign rd_data   = 8'h00;
  assign unused_rd = ^{rd_page, rd_col};
`endif

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx: directed SPI bytes, expected bytes queued,
// monitor compares on each byte_valid; framebuffer checked through the read port.
module tb_oled_spi_rx;

`ifdef OLED_RX_FB_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       mosi = 1'b0;
  logic       dc = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       byte_valid;
  logic       display_on;
  logic [2:0] rd_page = '0;
  logic [6:0] rd_col = '0;
  logic [7:0] rd_data;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       on;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   nvalid = 0;
  logic model_on = 1'b0;

  oled_spi_rx dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .mosi       (mosi),
    .dc         (dc),
    .cs_n       (cs_n),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .byte_valid (byte_valid),
    .display_on (display_on),
    .rd_page    (rd_page),
    .rd_col     (rd_col),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) begin
      exp_t e;
      nvalid++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got data=%h dc=%b, none expected",
                 byte_data, byte_dc);
      end else begin
        e = q.pop_front();
        if ({byte_data, byte_dc, display_on} !== {e.d, e.c, e.on}) begin
          n_fail++;
          $display("FAIL byte: got data=%h dc=%b on=%b, expected data=%h dc=%b on=%b",
                   byte_data, byte_dc, display_on, e.d, e.c, e.on);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = v[i];
      #40 spi_clk = 1'b1;
      #40 spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic d);
    exp_t e;
    if (!d && v == 8'hAF) model_on = 1'b1;
    if (!d && v == 8'hAE) model_on = 1'b0;
    e.d = v;
    e.c = d;
    e.on = model_on;
    q.push_back(e);
    cs_n = 1'b0;
    dc = d;
    send_bits(v, 8);
  endtask

  task automatic drain();
    int i = 0;
    while (q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d bytes never arrived, expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_check(input string nm, input logic [2:0] p,
                          input logic [6:0] c, input logic [7:0] e);
    logic [7:0] x;
    x = FB ? e : 8'h00;
    @(negedge clk);
    rd_page = p;
    rd_col = c;
    @(negedge clk);
    chk(nm, 32'(rd_data), 32'(x));
  endtask

  task automatic do_reset();
    @(negedge clk);
    cs_n = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_on = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    repeat (4) @(negedge clk);
    chk("rst_byte_data", 32'(byte_data), 32'h00);
    chk("rst_byte_dc", 32'(byte_dc), 32'h0);
    chk("rst_byte_valid", 32'(byte_valid), 32'h0);
    chk("rst_display_on", 32'(display_on), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    snap = nvalid;
    send_byte(8'hAF, 1'b0);
    drain();
    chk("af_one_pulse", 32'(nvalid - snap), 32'd1);
    send_byte(8'hAE, 1'b0);
    drain();
    chk("ae_display_off", 32'(display_on), 32'h0);

    send_byte(8'hA5, 1'b1);
    drain();
    rd_check("fb_0_0", 3'd0, 7'd0, 8'hA5);
    send_byte(8'h5A, 1'b1);
    drain();
    rd_check("fb_0_1", 3'd0, 7'd1, 8'h5A);

    send_byte(8'h21, 1'b0);
    send_byte(8'd10, 1'b0);
    send_byte(8'd12, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'd3, 1'b0);
    send_byte(8'd4, 1'b0);
    for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b1);
    drain();
    rd_check("win_3_10", 3'd3, 7'd10, 8'd7);
    rd_check("win_3_11", 3'd3, 7'd11, 8'd2);
    rd_check("win_3_12", 3'd3, 7'd12, 8'd3);
    rd_check("win_4_10", 3'd4, 7'd10, 8'd4);
    rd_check("win_4_11", 3'd4, 7'd11, 8'd5);
    rd_check("win_4_12", 3'd4, 7'd12, 8'd6);

    snap = nvalid;
    cs_n = 1'b0;
    dc = 1'b0;
    send_bits(8'hFF, 5);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h3C, 1'b0);
    drain();
    chk("partial_drop_count", 32'(nvalid - snap), 32'd1);

    do_reset();
    send_byte(8'h21, 1'b0);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAF, 1'b0);
    send_byte(8'h66, 1'b1);
    drain();
    chk("abort_display_on", 32'(display_on), 32'h1);
    rd_check("abort_fb_0_0", 3'd0, 7'd0, 8'h55);
    rd_check("abort_fb_0_1", 3'd0, 7'd1, 8'h66);

    send_byte(8'h21, 1'b0);
    send_byte(8'h7E, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h5B, 1'b1);
    drain();
    rd_check("wrap_0_126", 3'd0, 7'd126, 8'h11);
    rd_check("wrap_0_127", 3'd0, 7'd127, 8'h22);
    rd_check("wrap_0_0", 3'd0, 7'd0, 8'h33);
    rd_check("wrap_0_1", 3'd0, 7'd1, 8'h44);
    rd_check("wrap_1_126", 3'd1, 7'd126, 8'h5B);

    cs_n = 1'b0;
    dc = 1'b1;
    send_bits(8'hF0, 4);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_on = 1'b0;
    chk("rst_mid_display_off", 32'(display_on), 32'h0);
    snap = nvalid;
    send_byte(8'h81, 1'b1);
    drain();
    chk("rst_mid_one_pulse", 32'(nvalid - snap), 32'd1);
    rd_check("rst_mid_fb_0_0", 3'd0, 7'd0, 8'h81);

    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
